cbus_mem_responder: RTL and testbench
=====================================

Name: cbus_mem_responder

Overview:
- Memory-side responder for the cbus protocol that the cache/uncache arbiter drives.
- Accepts one `cbus_req_t` transaction at a time, inserts a programmable access latency, then streams read or write beats back on `cbus_resp_t`, with `last` on the final beat.
- Backed by an internal word-addressed RAM.
- Serves as the simulation/FPGA stand-in for the AXI-side memory, so ICache, DCache and uncached paths can be exercised without the AXI bridge.

Parameters:
- MEM_WORDS, 65536, RAM depth in 32-bit words; must be a power of two.
- LATENCY, 2, idle cycles between request acceptance and the first beat; 0 allowed.
- GAP, 0, idle cycles inserted between consecutive beats of one burst.

Ports:
- clk  input  1  clock
- resetn  input  1  reset, asynchronous, active-low
- creq  input  cbus_req_t  request fields used:
  - valid
  - is_write
  - size
  - addr[31:0]
  - strobe[3:0]
  - data[31:0]
  - len (MLEN1..MLEN16)
- cresp  output  cbus_resp_t  response fields: ready, last, data[31:0]

Behaviour:
- Protocol facts:
  - The initiator holds creq constant, including valid, for the whole transaction; only data/strobe change, after each write beat.
  - A beat transfers on any cycle with cresp.ready=1.
  - The initiator drops valid in the cycle after the beat that carried last=1.
- Reset (resetn=0, asynchronous):
  - State to IDLE; all counters cleared.
  - cresp.ready=0, cresp.last=0, cresp.data=0.
  - RAM contents are not cleared.
  - Reset mid-burst abandons the transaction with no partial-beat side effects beyond beats already written.
- States: IDLE, WAIT, BEAT, GAPW.
- IDLE:
  - If creq.valid, latch addr, is_write and len into registers.
  - beat_cnt=0; lat_cnt=LATENCY.
  - Go to WAIT, or directly to BEAT if LATENCY=0.
  - The request is sampled one cycle after valid rises, so the minimum read latency is LATENCY+1 cycles from valid to the first ready.
- WAIT: decrement lat_cnt; at 1, go to BEAT.
- BEAT:
  - ready=1 for exactly one cycle.
  - Read: data = RAM[cur_addr[log2(MEM_WORDS)+1:2]].
  - Write: each RAM byte i with creq.strobe[i]=1 takes creq.data byte i; write commits at clock edge.
  - last=1 iff beat_cnt==len.
  - If last: return to IDLE.
  - Else: beat_cnt+1, cur_addr+4, then go to GAPW (GAP>0) or stay in BEAT.
- GAPW: ready=0; count GAP cycles, then return to BEAT.
- Address rules:
  - Beats increment by 4 bytes (INCR burst).
  - addr[1:0] and size are ignored for indexing: the full word is returned, and strobe alone qualifies writes.
  - Index is taken modulo MEM_WORDS, so bursts wrap at the top of RAM silently.
  - No virtual translation; addr is physical.
- Outputs are registered-state driven: ready, last and data depend only on state and RAM, never combinationally on creq.
- ready=0 in IDLE, WAIT and GAPW; last=0 whenever ready=0.
- Back-to-back:
  - A new valid seen in IDLE the cycle after last starts a new transaction, with no extra bubble required.
  - valid still high in that cycle is treated as a new request; this is a protocol violation by the initiator and is not guarded.
- valid dropping mid-transaction (protocol violation): the responder continues to completion; bench flags it.
- Beat count per transaction = len+1 (MLEN1=0 encodes 1 beat, MLEN16=15 encodes 16 beats).

Decomposition:
- Shared package (common.svh) already holds cbus_req_t, cbus_resp_t, the len encodings and addr_t; add nothing there.
- Local state enum and counters stay in the module.
- Natural sub-module: `cbus_mem_bram`, a single-port byte-enable RAM with asynchronous read and synchronous write; it isolates FPGA inference from protocol logic.

Test Plan:
- Single read, LATENCY=2: preload word 0x100 = 0xDEADBEEF; creq valid, addr=0x100, len=MLEN1 → ready+last at cycle 3 after valid, data=0xDEADBEEF, then ready=0.
- 16-beat read (ICache line fill): RAM[0x200+4k]=k, len=MLEN16 → 16 consecutive ready beats with data 0..15; last only on beat 16.
- 4-beat write with strobes 4'b1111, 4'b0011, 4'b1000, 4'b0000 to 0x300 over RAM 0xFFFFFFFF:
  - data 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - Readback: 0x11111111, 0xFFFF2222, 0x33FFFFFF, 0xFFFFFFFF.
- GAP=1, len=MLEN4 read → ready pattern 1,0,1,0,1,0,1; last on the 4th ready.
- Wrap: MEM_WORDS=1024, burst MLEN4 from 0xFF8 → data from word indices 1022, 1023, 0, 1.
- Reset asserted during beat 2 of a 4-beat write → ready/last drop immediately; beat 1 is written, beats 2–4 are unchanged; a fresh read after reset release succeeds.

Source files
------------

// File: rtl/cbus_mem_responder_pkg.sv
// Purpose: shared cbus request/response payloads and burst-length encodings
//          for the memory-side responder and its RAM.
package cbus_mem_responder_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;
   localparam int unsigned LEN_W  = 4;
   localparam int unsigned SIZE_W = 3;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [LEN_W-1:0]  len_t;

   // Burst length encodings: value = beats - 1
   localparam len_t MLEN1  = 4'd0;
   localparam len_t MLEN2  = 4'd1;
   localparam len_t MLEN4  = 4'd3;
   localparam len_t MLEN8  = 4'd7;
   localparam len_t MLEN16 = 4'd15;

   typedef struct packed {
      logic              valid;
      logic              is_write;
      logic [SIZE_W-1:0] size;
      addr_t             addr;
      logic [STRB_W-1:0] strobe;
      logic [DATA_W-1:0] data;
      len_t              len;
   } cbus_req_t;

   typedef struct packed {
      logic              ready;
      logic              last;
      logic [DATA_W-1:0] data;
   } cbus_resp_t;

endpackage : cbus_mem_responder_pkg

// File: rtl/cbus_mem_bram.sv
// Purpose: single-port 32-bit RAM with per-byte write enables, asynchronous
//          read and synchronous write. Contents are never reset.
// Ports:
//   clk      clock
//   i_we     write enable (commits at the rising edge)
//   i_be     byte enables, bit i qualifies byte i of i_wdata
//   i_addr   word index
//   i_wdata  write data
//   o_rdata  read data for i_addr (combinational)
module cbus_mem_bram
   import cbus_mem_responder_pkg::*;
#(
   parameter int unsigned DEPTH = 65536,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [STRB_W-1:0] i_be,
   input  logic [AW-1:0]     i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Byte-masked write
   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int i = 0; i < int'(STRB_W); i++) begin
            if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
         end
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule : cbus_mem_bram

// File: rtl/cbus_mem_responder.sv
// Purpose: memory-side cbus responder. Accepts one request at a time, waits
//          LATENCY cycles, then streams len+1 INCR beats (GAP idle cycles
//          between beats) against an internal word-addressed RAM.
// Ports:
//   clk     clock
//   resetn  asynchronous active-low reset
//   creq    cbus request (valid, is_write, size, addr, strobe, data, len)
//   cresp   cbus response (ready, last, data)
module cbus_mem_responder
   import cbus_mem_responder_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 65536,
   parameter int unsigned LATENCY   = 2,
   parameter int unsigned GAP       = 0
) (
   input  logic       clk,
   input  logic       resetn,
   input  cbus_req_t  creq,
   output cbus_resp_t cresp
);

   localparam int unsigned AW    = $clog2(MEM_WORDS);
   localparam int unsigned CNT_W = 16;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_BEAT,
      S_GAPW
   } state_t;

   state_t            r_state,    w_state_nxt;
   addr_t             r_addr,     w_addr_nxt;
   logic              r_is_write, w_is_write_nxt;
   len_t              r_len,      w_len_nxt;
   logic [LEN_W-1:0]  r_beat_cnt, w_beat_cnt_nxt;
   logic [CNT_W-1:0]  r_lat_cnt,  w_lat_cnt_nxt;
   logic [CNT_W-1:0]  r_gap_cnt,  w_gap_cnt_nxt;

   logic              w_ready;
   logic              w_last;
   logic              w_we;
   logic [DATA_W-1:0] w_rdata;
   logic              w_unused;

   // State and transaction registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_is_write <= 1'b0;
         r_len      <= '0;
         r_beat_cnt <= '0;
         r_lat_cnt  <= '0;
         r_gap_cnt  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_addr     <= w_addr_nxt;
         r_is_write <= w_is_write_nxt;
         r_len      <= w_len_nxt;
         r_beat_cnt <= w_beat_cnt_nxt;
         r_lat_cnt  <= w_lat_cnt_nxt;
         r_gap_cnt  <= w_gap_cnt_nxt;
      end
   end

   // Next-state and beat control
   always_comb begin
      w_state_nxt    = r_state;
      w_addr_nxt     = r_addr;
      w_is_write_nxt = r_is_write;
      w_len_nxt      = r_len;
      w_beat_cnt_nxt = r_beat_cnt;
      w_lat_cnt_nxt  = r_lat_cnt;
      w_gap_cnt_nxt  = r_gap_cnt;
      w_ready        = 1'b0;
      w_last         = 1'b0;
      w_we           = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            if (creq.valid) begin
               w_addr_nxt     = creq.addr;
               w_is_write_nxt = creq.is_write;
               w_len_nxt      = creq.len;
               w_beat_cnt_nxt = '0;
               w_lat_cnt_nxt  = CNT_W'(LATENCY);
               w_state_nxt    = (LATENCY == 0) ? S_BEAT : S_WAIT;
            end
         end

         S_WAIT: begin
            w_lat_cnt_nxt = r_lat_cnt - CNT_W'(1);
            if (r_lat_cnt <= CNT_W'(1)) w_state_nxt = S_BEAT;
         end

         S_BEAT: begin
            w_ready = 1'b1;
            w_we    = r_is_write;
            w_last  = (r_beat_cnt == r_len);
            if (w_last) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_beat_cnt_nxt = r_beat_cnt + LEN_W'(1);
               // Address wraps modulo the RAM through index truncation
               w_addr_nxt     = r_addr + ADDR_W'(4);
               if (GAP != 0) begin
                  w_gap_cnt_nxt = CNT_W'(GAP);
                  w_state_nxt   = S_GAPW;
               end
            end
         end

         S_GAPW: begin
            w_gap_cnt_nxt = r_gap_cnt - CNT_W'(1);
            if (r_gap_cnt <= CNT_W'(1)) w_state_nxt = S_BEAT;
         end

         default: w_state_nxt = S_IDLE;
      endcase
   end

   cbus_mem_bram #(
      .DEPTH (MEM_WORDS),
      .AW    (AW)
   ) u_bram (
      .clk     (clk),
      .i_we    (w_we),
      .i_be    (creq.strobe),
      .i_addr  (r_addr[AW+1:2]),
      .i_wdata (creq.data),
      .o_rdata (w_rdata)
   );

   // Response decoded from the state register only; data forced to 0 off-beat
   assign cresp.ready = w_ready;
   assign cresp.last  = w_last;
   assign cresp.data  = w_ready ? w_rdata : '0;

   // size, byte offset and address bits above the RAM index are don't-care
   assign w_unused = ^{creq.size, r_addr};

endmodule : cbus_mem_responder

// File: tb/tb_cbus_mem_responder.sv
// Directed bench for cbus_mem_responder: two instances, one with the default
// latency and a 1024-word RAM (wrap), one with LATENCY=0 and GAP=1.
module tb_cbus_mem_responder;
   import cbus_mem_responder_pkg::*;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   cbus_req_t  req0, req1;
   cbus_resp_t rsp0, rsp1;

   int checks = 0;
   int errors = 0;

   logic [31:0] g_wd [16];
   logic [3:0]  g_sb [16];
   logic [31:0] g_ed [16];

   always #5 clk = ~clk;

   cbus_mem_responder #(
      .MEM_WORDS (1024),
      .LATENCY   (2),
      .GAP       (0)
   ) u_dut0 (
      .clk    (clk),
      .resetn (resetn),
      .creq   (req0),
      .cresp  (rsp0)
   );

   cbus_mem_responder #(
      .MEM_WORDS (65536),
      .LATENCY   (0),
      .GAP       (1)
   ) u_dut1 (
      .clk    (clk),
      .resetn (resetn),
      .creq   (req1),
      .cresp  (rsp1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int s, input cbus_req_t c);
      if (s == 0) req0 = c;
      else        req1 = c;
   endtask

   task automatic get_rsp(input int s, output cbus_resp_t r);
      if (s == 0) r = rsp0;
      else        r = rsp1;
   endtask

   // One full transaction; checks ready timing, last and read data per cycle.
   task automatic txn(input int s, input logic w, input logic [31:0] a,
                      input logic [3:0] len, input int lat, input int gap,
                      input string tag);
      cbus_req_t  c;
      cbus_resp_t r;
      int   beat = 0;
      int   cyc = 0;
      int   nxt;
      logic prev_beat = 1'b0;
      logic done = 1'b0;
      nxt = lat + 1;
      c = '0;
      c.valid    = 1'b1;
      c.is_write = w;
      c.size     = 3'd2;
      c.addr     = a;
      c.len      = len;
      c.data     = g_wd[0];
      c.strobe   = g_sb[0];
      set_req(s, c);
      while (!done) begin
         @(posedge clk);
         #1;
         cyc++;
         if (prev_beat && beat <= int'(len)) begin
            c.data   = g_wd[beat];
            c.strobe = g_sb[beat];
            set_req(s, c);
         end
         get_rsp(s, r);
         if (beat > int'(len)) begin
            c.valid = 1'b0;
            set_req(s, c);
            chk({tag, " ready after last"}, 32'(r.ready), 32'd0);
            done = 1'b1;
         end else begin
            chk({tag, " ready"}, 32'(r.ready), 32'(cyc == nxt));
            prev_beat = r.ready;
            if (r.ready) begin
               chk({tag, $sformatf(" last[%0d]", beat)}, 32'(r.last), 32'(beat == int'(len)));
               if (!w) chk({tag, $sformatf(" data[%0d]", beat)}, r.data, g_ed[beat]);
               beat++;
               nxt = cyc + 1 + gap;
            end
            if (cyc > 100) begin
               checks++;
               errors++;
               $error("FAIL %s timeout: observed %0d beats expected %0d", tag, beat, int'(len) + 1);
               c.valid = 1'b0;
               set_req(s, c);
               done = 1'b1;
            end
         end
      end
   endtask

   task automatic fill(input logic [31:0] v, input logic [3:0] sb);
      for (int k = 0; k < 16; k++) begin
         g_wd[k] = v;
         g_sb[k] = sb;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      cbus_req_t c;
      req0   = '0;
      req1   = '0;
      resetn = 1'b0;
      for (int k = 0; k < 16; k++) begin
         g_wd[k] = '0; g_sb[k] = '0; g_ed[k] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("reset ready0", 32'(rsp0.ready), 32'd0);
      chk("reset last0",  32'(rsp0.last),  32'd0);
      chk("reset data0",  rsp0.data,       32'd0);
      chk("reset ready1", 32'(rsp1.ready), 32'd0);
      resetn = 1'b1;
      @(posedge clk);
      #1;

      // Single-word write then read, first ready 3 cycles after valid
      fill(32'hDEADBEEF, 4'hF);
      txn(0, 1'b1, 32'h100, MLEN1, 2, 0, "wr100");
      g_ed[0] = 32'hDEADBEEF;
      txn(0, 1'b0, 32'h100, MLEN1, 2, 0, "rd100");
      txn(0, 1'b0, 32'h103, MLEN1, 2, 0, "rd103");

      // 16-beat line fill
      for (int k = 0; k < 16; k++) begin
         g_wd[k] = 32'(k); g_sb[k] = 4'hF; g_ed[k] = 32'(k);
      end
      txn(0, 1'b1, 32'h200, MLEN16, 2, 0, "wr200");
      txn(0, 1'b0, 32'h200, MLEN16, 2, 0, "rd200");

      // Byte-strobe merge over an all-ones background
      fill(32'hFFFFFFFF, 4'hF);
      txn(0, 1'b1, 32'h300, MLEN4, 2, 0, "bg300");
      g_wd[0] = 32'h11111111; g_sb[0] = 4'b1111;
      g_wd[1] = 32'h22222222; g_sb[1] = 4'b0011;
      g_wd[2] = 32'h33333333; g_sb[2] = 4'b1000;
      g_wd[3] = 32'h44444444; g_sb[3] = 4'b0000;
      txn(0, 1'b1, 32'h300, MLEN4, 2, 0, "wr300");
      g_ed[0] = 32'h11111111;
      g_ed[1] = 32'hFFFF2222;
      g_ed[2] = 32'h33FFFFFF;
      g_ed[3] = 32'hFFFFFFFF;
      txn(0, 1'b0, 32'h300, MLEN4, 2, 0, "rd300");

      // Wrap at the top of a 1024-word RAM: indices 1022, 1023, 0, 1
      g_wd[0] = 32'hA0A0A0A0; g_wd[1] = 32'hA1A1A1A1;
      g_wd[2] = 32'hA2A2A2A2; g_wd[3] = 32'hA3A3A3A3;
      for (int k = 0; k < 4; k++) begin
         g_sb[k] = 4'hF; g_ed[k] = g_wd[k];
      end
      txn(0, 1'b1, 32'hFF8, MLEN4, 2, 0, "wrFF8");
      txn(0, 1'b0, 32'hFF8, MLEN4, 2, 0, "rdFF8");
      g_ed[0] = 32'hA2A2A2A2; g_ed[1] = 32'hA3A3A3A3;
      txn(0, 1'b0, 32'h000, MLEN2, 2, 0, "rd000");
      g_ed[0] = 32'hA0A0A0A0; g_ed[1] = 32'hA1A1A1A1;
      txn(0, 1'b0, 32'h1FF8, MLEN2, 2, 0, "rd1FF8");

      // LATENCY=0, GAP=1: ready 1,0,1,0,1,0,1
      for (int k = 0; k < 4; k++) begin
         g_wd[k] = 32'hC0DE0000 + 32'(k); g_sb[k] = 4'hF; g_ed[k] = g_wd[k];
      end
      txn(1, 1'b1, 32'h40, MLEN4, 0, 1, "gap wr");
      txn(1, 1'b0, 32'h40, MLEN4, 0, 1, "gap rd");

      // Reset during beat 2 of a 4-beat write
      fill(32'hFFFFFFFF, 4'hF);
      txn(0, 1'b1, 32'h380, MLEN4, 2, 0, "bg380");
      c = '0;
      c.valid = 1'b1; c.is_write = 1'b1; c.size = 3'd2;
      c.addr = 32'h380; c.len = MLEN4;
      c.data = 32'hA5A5A5A5; c.strobe = 4'hF;
      req0 = c;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("rst beat1 ready", 32'(rsp0.ready), 32'd1);
      @(posedge clk);
      #1;
      c.data = 32'h5A5A5A5A;
      req0 = c;
      chk("rst beat2 ready", 32'(rsp0.ready), 32'd1);
      chk("rst beat2 last",  32'(rsp0.last),  32'd0);
      resetn = 1'b0;
      #1;
      chk("rst ready drop", 32'(rsp0.ready), 32'd0);
      chk("rst last drop",  32'(rsp0.last),  32'd0);
      chk("rst data zero",  rsp0.data,       32'd0);
      req0 = '0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      @(posedge clk);
      #1;
      g_ed[0] = 32'hA5A5A5A5;
      g_ed[1] = 32'hFFFFFFFF;
      g_ed[2] = 32'hFFFFFFFF;
      g_ed[3] = 32'hFFFFFFFF;
      txn(0, 1'b0, 32'h380, MLEN4, 2, 0, "rd380");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_cbus_mem_responder
